// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer driving the PC mux select, fetch qualification,
// redirect flush, boot start, load-use stall and halt/resume.
module fetch_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic             br_taken,
    input  logic             br_reg,
    input  logic             halt_req,
    input  logic             resume,
    output logic [1:0]       PCSrc,
    output logic             if_valid,
    output logic             if_id_flush,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_cnt
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;

    state_t     state, state_nxt;
    logic [2:0] fcnt, fcnt_nxt;
    logic       run, busy, redir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fcnt      <= '0;
            fetch_cnt <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            if (if_valid) fetch_cnt <= fetch_cnt + CNT_W'(1);
        end
    end

    // A redirect loads the remaining squash cycles; the redirect cycle itself is the first.
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = '0;
        case (state)
            IDLE: state_nxt = start ? RUN : IDLE;
            RUN: begin
                if (fcnt != 3'd0) fcnt_nxt = fcnt - 3'd1;
                else if (br_reg || br_taken) fcnt_nxt = 3'(FLUSH_CYCLES - 1);
                else if (halt_req) state_nxt = HALT;
            end
            HALT: state_nxt = resume ? RUN : HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        run         = state == RUN;
        busy        = fcnt != 3'd0;
        redir       = br_reg || br_taken;
        if_id_flush = run && (busy || redir);
        if_valid    = run && !busy && !redir && !halt_req && !stall;
        halted      = state == HALT;
        PCSrc       = !run ? 2'b11 :
                      busy ? 2'b00 :
                      br_reg ? 2'b10 :
                      br_taken ? 2'b01 :
                      (halt_req || stall) ? 2'b11 : 2'b00;
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench driving two fetch_ctrl instances (FLUSH_CYCLES=3/CNT_W=4
// and defaults) with directed then random stimulus against a behavioural model.
module tb_fetch_ctrl;
    typedef struct packed {
        logic [1:0]  pc;
        logic        v;
        logic        f;
        logic        h;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 0;
    logic rst_n = 0, start = 0, stall = 0, br_taken = 0, br_reg = 0, halt_req = 0, resume = 0;
    logic [1:0]  a_pc, b_pc;
    logic        a_v, a_f, a_h, b_v, b_f, b_h;
    logic [3:0]  a_cnt;
    logic [31:0] b_cnt;

    int errors = 0, checks = 0;
    exp_t qa[$], qb[$];

    // Model: mode 0 = idle, 1 = running, 2 = halted; left = squash cycles still owed.
    int     mode[2], left[2];
    longint cnt[2];
    int     flush_n[2] = '{3, 1};
    longint modulus[2] = '{longint'(16), longint'(1) << 32};

    always #5 clk = ~clk;

    fetch_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .br_taken(br_taken),
        .br_reg(br_reg), .halt_req(halt_req), .resume(resume), .PCSrc(a_pc),
        .if_valid(a_v), .if_id_flush(a_f), .halted(a_h), .fetch_cnt(a_cnt));

    fetch_ctrl u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .br_taken(br_taken),
        .br_reg(br_reg), .halt_req(halt_req), .resume(resume), .PCSrc(b_pc),
        .if_valid(b_v), .if_id_flush(b_f), .halted(b_h), .fetch_cnt(b_cnt));

    function automatic exp_t expect_of(int i);
        exp_t e;
        e = '{pc: 2'b11, v: 1'b0, f: 1'b0, h: 1'b0, cnt: 32'(cnt[i])};
        if (!rst_n) e.cnt = 0;
        else if (mode[i] == 2) e.h = 1'b1;
        else if (mode[i] == 1) begin
            if (left[i] > 0) begin e.pc = 2'b00; e.f = 1'b1; end
            else if (br_reg) begin e.pc = 2'b10; e.f = 1'b1; end
            else if (br_taken) begin e.pc = 2'b01; e.f = 1'b1; end
            else if (!halt_req && !stall) begin e.pc = 2'b00; e.v = 1'b1; end
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin mode[i] = 0; left[i] = 0; cnt[i] = 0; end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) continue;
            if (expect_of(i).v) cnt[i] = (cnt[i] + 1) % modulus[i];
            if (mode[i] == 0) mode[i] = start ? 1 : 0;
            else if (mode[i] == 2) mode[i] = resume ? 1 : 2;
            else if (left[i] > 0) left[i]--;
            else if (br_reg || br_taken) left[i] = flush_n[i] - 1;
            else if (halt_req) mode[i] = 2;
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic st, input logic bt,
                       input logic br, input logic hr, input logic rs);
        @(negedge clk);
        rst_n = r; start = s; stall = st; br_taken = bt; br_reg = br; halt_req = hr; resume = rs;
        if (!r) model_reset();
        qa.push_back(expect_of(0));
        qb.push_back(expect_of(1));
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_pcsrc", 32'(a_pc), 32'(e.pc));
                chk("a_if_valid", 32'(a_v), 32'(e.v));
                chk("a_flush", 32'(a_f), 32'(e.f));
                chk("a_halted", 32'(a_h), 32'(e.h));
                chk("a_fetch_cnt", 32'(a_cnt), e.cnt);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_pcsrc", 32'(b_pc), 32'(e.pc));
                chk("b_if_valid", 32'(b_v), 32'(e.v));
                chk("b_flush", 32'(b_f), 32'(e.f));
                chk("b_halted", 32'(b_h), 32'(e.h));
                chk("b_fetch_cnt", b_cnt, e.cnt);
            end
        end
    end

    initial begin
        model_reset();
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        idle(10);
        cyc(1, 0, 1, 1, 0, 1, 0);
        idle(3);
        cyc(1, 0, 0, 1, 1, 0, 0);
        idle(3);
        cyc(1, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        idle(2);
        cyc(1, 0, 0, 0, 0, 0, 1);
        idle(1);
        for (int k = 0; k < 4; k++) cyc(1, 0, 1, 0, 0, 0, 0);
        idle(2);
        cyc(1, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        idle(2);
        idle(17);
        cyc(1, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        idle(3);
        for (int k = 0; k < 3000; k++)
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                $urandom_range(0, 3) == 0);
        @(negedge clk);
        #5;
        chk("scoreboard_drain", 32'(qa.size() + qb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
